// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: requester ids and slot FSM states.
package vram_arbiter_pkg;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        VREQ_SCREEN = 2'd0,
        VREQ_CPU    = 2'd1,
        VREQ_UP     = 2'd2,
        VREQ_DMA    = 2'd3
    } vram_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        TURN = 2'd3
    } vram_arb_state_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational winner select: screen > cpu > {ulaplus, dma}; the
// round-robin candidate between ulaplus and dma jumps above the cpu
// when the starvation flag is raised.
module vram_arb_pick import vram_arbiter_pkg::*; (
    input  logic [NREQ-1:0] req,
    input  vram_req_t       rr,
    input  logic            starve,
    output logic [NREQ-1:0] grant,
    output vram_req_t       idx
);

    logic      lo_any;
    vram_req_t lo_idx;

    // pick the low-priority candidate, rr breaking ties
    always_comb begin
        lo_any = req[VREQ_UP] | req[VREQ_DMA];
        if (req[VREQ_UP] && req[VREQ_DMA])
            lo_idx = rr;
        else if (req[VREQ_UP])
            lo_idx = VREQ_UP;
        else
            lo_idx = VREQ_DMA;
    end

    // overall priority resolution
    always_comb begin
        grant = '0;
        idx   = VREQ_SCREEN;
        if (req[VREQ_SCREEN]) begin
            idx = VREQ_SCREEN;
            grant[VREQ_SCREEN] = 1'b1;
        end else if (starve && lo_any) begin
            idx = lo_idx;
            grant[lo_idx] = 1'b1;
        end else if (req[VREQ_CPU]) begin
            idx = VREQ_CPU;
            grant[VREQ_CPU] = 1'b1;
        end else if (lo_any) begin
            idx = lo_idx;
            grant[lo_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shared video/system SRAM arbiter: fixed 2-cycle slots (ACC1 address
// setup, ACC2 data), one TURN cycle when a read follows a write.
// Optional starvation guard enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter import vram_arbiter_pkg::*; #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [18:0] addr0,
    input  logic [18:0] addr1,
    input  logic [18:0] addr2,
    input  logic [18:0] addr3,
    input  logic [3:0]  we,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic [7:0]  wdata2,
    input  logic [7:0]  wdata3,
    output logic [3:0]  ack,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic [1:0]  rid,
    output logic [18:0] va,
    output logic [7:0]  vd_out,
    output logic        vd_oe,
    input  logic [7:0]  vd_in,
    output logic        n_vrd,
    output logic        n_vwr
);

    vram_arb_state_t   state;
    vram_req_t         cur_id;
    vram_req_t         rr;
    vram_req_t         win_idx;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [NREQ-1:0]   grant;
    logic              starve;
    logic              win_we;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              need_turn;
    logic              take;

    assign va     = cur_addr;
    assign vd_out = cur_wdata;

    vram_arb_pick u_pick (
        .req    (req),
        .rr     (rr),
        .starve (starve),
        .grant  (grant),
        .idx    (win_idx)
    );

    // route the winner's address, data and direction
    always_comb begin
        win_we = we[win_idx];
        case (win_idx)
            VREQ_SCREEN: begin addr_mux = addr0; wdata_mux = wdata0; end
            VREQ_CPU:    begin addr_mux = addr1; wdata_mux = wdata1; end
            VREQ_UP:     begin addr_mux = addr2; wdata_mux = wdata2; end
            default:     begin addr_mux = addr3; wdata_mux = wdata3; end
        endcase
    end

    // decision points: IDLE, TURN, and ACC2 unless a read must wait out a turnaround
    always_comb begin
        need_turn = (state == ACC2) && cur_we && (|grant) && !win_we;
        take      = (|grant) && !need_turn &&
                    ((state == IDLE) || (state == ACC2) || (state == TURN));
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    // count cpu wins while a low-priority request waits; any low win or no waiter clears it
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!(req[VREQ_UP] || req[VREQ_DMA]))
            starve_cnt <= '0;
        else if (take && (grant[VREQ_UP] || grant[VREQ_DMA]))
            starve_cnt <= '0;
        else if (take && grant[VREQ_CPU] && (starve_cnt < LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign starve = (starve_cnt >= LIMIT);
`else
    // without the guard the limit has no effect and the cpu always outranks low priority
    assign starve = 1'b0 && (STARVE_LIMIT > 0);
`endif

    // slot FSM with registered SRAM strobes, grant pulse and read return
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rid       <= '0;
            cur_id    <= VREQ_SCREEN;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            vd_oe     <= 1'b0;
            n_vrd     <= 1'b1;
            n_vwr     <= 1'b1;
            rr        <= VREQ_UP;
        end else begin
            ack    <= '0;
            rvalid <= 1'b0;
            case (state)
                ACC1: begin
                    state <= ACC2;
                    n_vwr <= ~cur_we;
                end
                ACC2: begin
                    if (!cur_we) begin
                        rdata  <= vd_in;
                        rid    <= cur_id;
                        rvalid <= 1'b1;
                    end
                    if (!take) begin
                        state <= need_turn ? TURN : IDLE;
                        vd_oe <= 1'b0;
                        n_vrd <= 1'b1;
                        n_vwr <= 1'b1;
                    end
                end
                TURN: begin
                    if (!take)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (take) begin
                state     <= ACC1;
                ack       <= grant;
                cur_id    <= win_idx;
                cur_we    <= win_we;
                cur_addr  <= addr_mux;
                cur_wdata <= wdata_mux;
                vd_oe     <= win_we;
                n_vrd     <= win_we;
                n_vwr     <= 1'b1;
                if (grant[VREQ_UP] || grant[VREQ_DMA])
                    rr <= (win_idx == VREQ_UP) ? VREQ_DMA : VREQ_UP;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed table, hand sequences, and a
// randomized run against a slot-level reference model with an SRAM model.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int LIMIT = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk28 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [18:0] addr [4];
    logic [7:0]  wdata [4];
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [1:0]  rid;
    logic [18:0] va;
    logic [7:0]  vd_out;
    logic        vd_oe;
    logic [7:0]  vd_in = '0;
    logic        n_vrd;
    logic        n_vwr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vwr_pulses = 0;

    logic [7:0] sram [logic [18:0]];
    logic [7:0] emem [logic [18:0]];

    typedef struct { int id; logic [7:0] d; int due; } rd_t;
    rd_t rq[$];

    typedef struct { logic [3:0] r; logic [3:0] w; logic [3:0] exp_ack; logic exp_nvrd; logic exp_oe; } vec_t;
    vec_t tbl [10];

    always #18 clk28 = ~clk28;

    vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk28(clk28), .rst_n(rst_n), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .we(we),
        .wdata0(wdata[0]), .wdata1(wdata[1]), .wdata2(wdata[2]), .wdata3(wdata[3]),
        .ack(ack), .rdata(rdata), .rvalid(rvalid), .rid(rid),
        .va(va), .vd_out(vd_out), .vd_oe(vd_oe), .vd_in(vd_in),
        .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // one clock; SRAM pins serviced at the falling edge
    task automatic tick();
        @(posedge clk28);
        @(negedge clk28);
        cyc++;
        if (!n_vwr) begin
            sram[va] = vd_out;
            vwr_pulses++;
        end
        if (!n_vrd && sram.exists(va)) vd_in = sram[va];
        else vd_in = 8'h00;
    endtask

    task automatic do_reset();
        req = '0;
        we = '0;
        vd_in = '0;
        rst_n = 1'b0;
        @(negedge clk28);
        @(negedge clk28);
        rst_n = 1'b1;
    endtask

    function automatic int winner(input logic [3:0] r, input int fav, input bit st);
        int lo;
        lo = -1;
        if (r[2] && r[3]) lo = fav;
        else if (r[2]) lo = 2;
        else if (r[3]) lo = 3;
        if (r[0]) return 0;
        if (st && lo >= 0) return lo;
        if (r[1]) return 1;
        return lo;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int seen[$];
        int cpu_n;
        bit dma_seen;
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end

        // reset state
        @(negedge clk28);
        @(negedge clk28);
        chk("rst_ack", ack, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_va", va, 0);
        chk("rst_vd_out", vd_out, 0);
        chk("rst_vd_oe", vd_oe, 0);
        chk("rst_n_vrd", n_vrd, 1);
        chk("rst_n_vwr", n_vwr, 1);

        // single-decision priority table, fresh reset each vector
        tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[1] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[3] = '{4'b0110, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[4] = '{4'b1100, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[5] = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0};
        tbl[6] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1};
        tbl[7] = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[9] = '{4'b1010, 4'b1000, 4'b0010, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            req = tbl[i].r;
            we = tbl[i].w;
            tick();
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].exp_ack);
            chk($sformatf("tbl%0d_n_vrd", i), n_vrd, tbl[i].exp_nvrd);
            chk($sformatf("tbl%0d_vd_oe", i), vd_oe, tbl[i].exp_oe);
            req = '0;
            we = '0;
            repeat (4) tick();
        end

        // single cpu read
        do_reset();
        sram[19'h12345] = 8'hA5;
        addr[1] = 19'h12345;
        req = 4'b0010;
        tick();
        chk("rd_ack", ack, 4'b0010);
        chk("rd_nvrd1", n_vrd, 0);
        chk("rd_va", va, 19'h12345);
        req = '0;
        tick();
        chk("rd_nvrd2", n_vrd, 0);
        chk("rd_ack_once", ack, 0);
        chk("rd_rvalid_early", rvalid, 0);
        tick();
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_rid", rid, 1);
        chk("rd_nvrd3", n_vrd, 1);
        repeat (2) tick();

        // screen and cpu together: back-to-back slots
        do_reset();
        addr[0] = 19'h00010;
        addr[1] = 19'h00020;
        req = 4'b0011;
        tick();
        chk("bb_ack0", ack, 4'b0001);
        req = 4'b0010;
        tick();
        chk("bb_gap_ack", ack, 0);
        chk("bb_gap_nvrd", n_vrd, 0);
        tick();
        chk("bb_ack1", ack, 4'b0010);
        chk("bb_nvrd", n_vrd, 0);
        req = '0;
        repeat (3) tick();

        // cpu write then screen read with turnaround
        do_reset();
        vwr_pulses = 0;
        addr[1] = 19'h00100;
        wdata[1] = 8'h5A;
        we = 4'b0010;
        req = 4'b0010;
        tick();
        chk("wr_ack", ack, 4'b0010);
        chk("wr_acc1_oe", vd_oe, 1);
        chk("wr_acc1_vd", vd_out, 8'h5A);
        chk("wr_acc1_nvwr", n_vwr, 1);
        chk("wr_acc1_va", va, 19'h00100);
        addr[0] = 19'h00200;
        we = '0;
        req = 4'b0001;
        tick();
        chk("wr_acc2_nvwr", n_vwr, 0);
        chk("wr_acc2_vd", vd_out, 8'h5A);
        tick();
        chk("turn_oe", vd_oe, 0);
        chk("turn_nvwr", n_vwr, 1);
        chk("turn_nvrd", n_vrd, 1);
        chk("turn_ack", ack, 0);
        tick();
        chk("turn_scr_ack", ack, 4'b0001);
        chk("turn_scr_nvrd", n_vrd, 0);
        req = '0;
        repeat (3) tick();
        chk("wr_pulses", vwr_pulses, 1);
        chk("wr_mem", sram.exists(19'h00100) ? sram[19'h00100] : 8'h00, 8'h5A);

        // ulaplus and dma held: round robin from ulaplus
        do_reset();
        req = 4'b1100;
        for (int c = 0; c < 20 && seen.size() < 4; c++) begin
            tick();
            if (ack != 0) seen.push_back(int'(ack));
        end
        chk("rr_count", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_ack%0d", i), (i < seen.size()) ? seen[i] : 0, (i % 2 == 0) ? 4 : 8);
        req = '0;
        repeat (3) tick();

        // cpu continuous, dma pending
        do_reset();
        req = 4'b1010;
        cpu_n = 0;
        dma_seen = 1'b0;
        for (int c = 0; c < 250 && !dma_seen; c++) begin
            tick();
            if (ack == 4'b0010) cpu_n++;
            if (ack == 4'b1000) dma_seen = 1'b1;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("starve_dma_acked", dma_seen, 1);
        chk("starve_cpu_slots", cpu_n, LIMIT);
`else
        chk("strict_dma_never", dma_seen, 0);
        chk("strict_cpu_slots_ge100", cpu_n >= 100, 1);
`endif
        req = '0;
        repeat (3) tick();

        // async reset during write data phase
        do_reset();
        addr[1] = 19'h00333;
        wdata[1] = 8'hC3;
        we = 4'b0010;
        req = 4'b0010;
        tick();
        req = '0;
        we = '0;
        tick();
        chk("ar_pre_nvwr", n_vwr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_nvwr", n_vwr, 1);
        chk("ar_oe", vd_oe, 0);
        chk("ar_ack", ack, 0);
        @(negedge clk28);
        rst_n = 1'b1;
        req = 4'b1100;
        tick();
        chk("ar_first_ack", ack, 4'b0100);
        req = '0;
        repeat (3) tick();

        // randomized run against the slot-level model
        begin
            logic [18:0] pool [8];
            bit pend [4];
            int prob [4];
            int free_at, fav, scnt, w;
            bit turn_flag, prev_oe, prev_nvwr_low;
            logic [3:0] r, rw, exp_ack;
            prob = '{20, 40, 15, 15};
            for (int i = 0; i < 8; i++) pool[i] = 19'($urandom);
            for (int i = 0; i < 4; i++) pend[i] = 1'b0;
            do_reset();
            sram.delete();
            emem.delete();
            rq.delete();
            free_at = 0;
            fav = 2;
            scnt = 0;
            turn_flag = 1'b0;
            prev_oe = 1'b0;
            prev_nvwr_low = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                r = req;
                rw = we;
                tick();
                exp_ack = '0;
                w = winner(r, fav, GUARD && (scnt >= LIMIT));
                if (cyc >= free_at) begin
                    if (w < 0) turn_flag = 1'b0;
                    else if (turn_flag && !rw[w]) begin
                        turn_flag = 1'b0;
                        free_at = cyc + 1;
                    end else exp_ack[w] = 1'b1;
                end
                chk("rnd_ack", ack, exp_ack);
                if (exp_ack != 0) begin
                    free_at = cyc + 2;
                    turn_flag = rw[w];
                    if (rw[w]) emem[addr[w]] = wdata[w];
                    else rq.push_back('{w, emem.exists(addr[w]) ? emem[addr[w]] : 8'h00, cyc + 2});
                    if (w >= 2) fav = (w == 2) ? 3 : 2;
                end
                if (r[3:2] == 0) scnt = 0;
                else if (exp_ack[2] || exp_ack[3]) scnt = 0;
                else if (exp_ack[1] && scnt < LIMIT) scnt++;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    chk("rnd_rvalid", rvalid, 1);
                    chk("rnd_rdata", rdata, rq[0].d);
                    chk("rnd_rid", rid, rq[0].id);
                    void'(rq.pop_front());
                end else chk("rnd_rvalid_idle", rvalid, 0);
                chk("rnd_contention", !n_vrd && vd_oe, 0);
                chk("rnd_turnaround", prev_oe && !n_vrd, 0);
                chk("rnd_vwr_width", prev_nvwr_low && !n_vwr, 0);
                prev_oe = vd_oe;
                prev_nvwr_low = !n_vwr;
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) pend[i] = 1'b0;
                    if (i == 0 && pend[0] && $urandom_range(0, 99) < 5) pend[0] = 1'b0;
                    else if (!pend[i] && $urandom_range(0, 99) < prob[i]) begin
                        pend[i] = 1'b1;
                        addr[i] = pool[$urandom_range(0, 7)];
                        we[i] = (i != 0) && ($urandom_range(0, 2) == 0);
                        wdata[i] = 8'($urandom);
                    end
                    req[i] = pend[i];
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Schedules the shared external video/system SRAM (va/vd, n_vrd/n_vwr) among four requesters: screen fetch, CPU memory cycle, ULAplus palette write and a DMA port. Sits between the requesters and the SRAM pins, under memcontrol. Issues fixed 2-cycle access slots, with a turnaround cycle after writes. Uses strict priority for screen and CPU, round-robin between ULAplus and DMA, and an optional starvation guard.

## Interface
- STARVE_LIMIT, 8: CPU-won slots a pending low-priority request tolerates before it is promoted (1..15).
- clk28  in  1  28 MHz system clock; all logic on its rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- req[3:0]  in  4  Level requests; index 0=screen, 1=cpu, 2=ulaplus, 3=dma.
- addr0..addr3  in  19 each  Per-requester SRAM address; stable while req is high.
- we[3:0]  in  4  Per-requester write enable.
- wdata0..wdata3  in  8 each  Per-requester write data.
- ack[3:0]  out  4  One-hot, 1-cycle grant pulse; the requester may change addr/we/wdata on the next cycle.
- rdata  out  8  Last read byte; held until the next read.
- rvalid  out  1  1-cycle pulse when rdata is new.
- rid  out  2  Requester index belonging to rdata; valid with rvalid.
- va  out  19  SRAM address.
- vd_out  out  8  SRAM write data.
- vd_oe  out  1  Enables the vd_out pin driver.
- vd_in  in  8  SRAM read data.
- n_vrd  out  1  SRAM output enable, active low.
- n_vwr  out  1  SRAM write strobe, active low.

## Operation
- States:
  - IDLE: no access.
  - ACC1: address setup phase.
  - ACC2: data phase.
  - TURN: bus turnaround after a write.
- Arbitration is evaluated in IDLE, and in ACC2 when no TURN is needed, so back-to-back slots are possible.
- Winner latched into cur_id/cur_addr/cur_we/cur_wdata; ack[cur_id] pulses in the first ACC1 cycle.
- Priority order:
  - screen > cpu > {ulaplus, dma}.
  - ulaplus vs dma uses round-robin pointer rr. rr points to the loser of the last low-priority grant. Reset value: ulaplus.
- ACC1:
  - va=cur_addr.
  - Read: n_vrd=0.
  - Write: vd_oe=1, vd_out=cur_wdata, n_vwr=1.
- ACC2:
  - Read: n_vrd=0; vd_in is sampled at the end of the cycle.
  - Write: vd_oe=1, n_vwr=0.
- Next state after ACC2:
  - Write slot followed by a read grant → TURN (vd_oe=0, strobes high) → ACC1.
  - Any request pending otherwise → ACC1.
  - No request → IDLE.
- After a write slot, a following write slot goes straight to ACC1.
- Read completion: rdata and rid are registered; rvalid pulses in the cycle after ACC2.
- Requester dropping req before ack: the request is withdrawn and no access occurs. Screen fetch uses this to cancel.
- Requester holding req after ack: treated as a new request, evaluated at the next decision point.
- Reset (async, any state):
  - state=IDLE, ack=0, rvalid=0, rdata=0, rid=0.
  - va=0, vd_out=0, vd_oe=0, n_vrd=1, n_vwr=1.
  - rr=ulaplus, starve counter=0.
  - An access in flight is aborted; n_vwr deasserts immediately.

## Timing
- Request in IDLE → ack 1 cycle later (first ACC1 cycle).
- Slot length:
  - Read: 2 cycles.
  - Write: 2 cycles, plus 1 TURN cycle when a read follows.
- Peak rate: 14 M accesses/s.
- Read data is available to the requester (rvalid) 3 cycles after the grant decision.
- Worst-case screen wait: 3 cycles (write slot in progress plus TURN).
- n_vwr low for exactly 1 cycle per write; va and vd_out are stable 1 cycle before and during n_vwr low.
- Simultaneous requests resolve by priority in the same decision cycle; losers keep req and are re-evaluated at the next decision point.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined:
  - 4-bit counter increments on each CPU grant while ulaplus or dma is pending, saturating at STARVE_LIMIT.
  - At STARVE_LIMIT, the low-priority candidate chosen by rr outranks the CPU, never the screen.
  - The counter clears on any low-priority grant, or when no low-priority request is pending.
- Undefined: no counter; strict priority, so the CPU can starve ulaplus and dma indefinitely.

## Structure
- Package common gets:
  - vram_req_t enum: VREQ_SCREEN, VREQ_CPU, VREQ_UP, VREQ_DMA.
  - vram_arb_state_t enum: IDLE, ACC1, ACC2, TURN.
- Sub-module vram_arb_pick: combinational winner select. Inputs req, rr, starve flag; outputs one-hot grant and index.
- Everything else (FSM, latches, counter) lives in vram_arbiter.

## Test plan
- Single cpu read, addr=0x12345, SRAM returns 0xA5 → ack[1] in cycle 1; n_vrd low in cycles 1–2; rvalid with rdata=0xA5, rid=1 in cycle 3.
- Screen and cpu requesting in the same cycle → ack[0] first, ack[1] exactly 2 cycles later, with no IDLE gap.
- cpu write (0x00100←0x5A) immediately followed by a screen read → one n_vwr pulse with vd_out=0x5A, one TURN cycle with vd_oe=0, then screen ACC1.
- ulaplus and dma held high continuously, cpu idle → acks alternate 2,3,2,3, starting with ulaplus after reset.
- Guard defined, cpu requesting continuously, dma pending → dma acked after exactly 8 cpu slots. Guard undefined → dma never acked within 100 slots.
- rst_n asserted during ACC2 of a write → n_vwr=1 and vd_oe=0 asynchronously. After release: IDLE, rr=ulaplus; the first request is acked 1 cycle later.
